// File: rtl/pwm_frame_sequencer.sv
// Frame sequencer for the multi-stage PWM datapath: a double-buffered duty set
// replayed as a start/data burst once per fixed-length frame.
module pwm_frame_sequencer #(
   parameter int STAGE       = 8,
   parameter int DWIDTH      = 8,
   parameter int BEAT_DIV    = 32,
   parameter int FRAME_BEATS = 24
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic                     wr_en,
   input  logic [$clog2(STAGE)-1:0] wr_addr,
   input  logic [DWIDTH-1:0]        wr_data,
   input  logic                     commit,
   output logic                     start,
   output logic [DWIDTH-1:0]        data,
   output logic                     busy,
   output logic                     commit_pending,
   output logic                     frame_done,
   output logic [15:0]              frame_cnt
);

   localparam int AW  = $clog2(STAGE);
   localparam int IW  = $clog2(STAGE + 1);
   localparam int DVW = $clog2(BEAT_DIV);
   localparam int FW  = $clog2(FRAME_BEATS);

   localparam logic [AW:0]     STAGE_A  = (AW + 1)'(STAGE);
   localparam logic [IW-1:0]   STAGE_I  = IW'(STAGE);
   localparam logic [DVW-1:0]  DIV_LAST = DVW'(BEAT_DIV - 1);
   localparam logic [FW-1:0]   FB_LAST  = FW'(FRAME_BEATS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      GAP  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                start_q, start_d;
   logic [DWIDTH-1:0]   data_q, data_d;
   logic                busy_q, busy_d;
   logic                commit_pending_q, commit_pending_d;
   logic                frame_done_q, frame_done_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;
   logic [DVW-1:0]      div_q, div_d;
   logic [FW-1:0]       fb_q, fb_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [DWIDTH-1:0]   shadow_q [STAGE];
   logic [DWIDTH-1:0]   active_q [STAGE];
   logic                tick_s;
   logic                launch_s;
   logic                wr_ok_s;

   assign tick_s  = (div_q == DIV_LAST);
   assign wr_ok_s = ({1'b0, wr_addr} < STAGE_A);

   // Next-state logic: beat timing, burst replay and frame boundary handling.
   always_comb begin
      state_d          = state_q;
      start_d          = start_q;
      data_d           = data_q;
      idx_d            = idx_q;
      fb_d             = fb_q;
      div_d            = {DVW{1'b0}};
      frame_done_d     = 1'b0;
      frame_cnt_d      = frame_cnt_q;
      launch_s         = 1'b0;
      commit_pending_d = commit_pending_q | commit;

      if (state_q != IDLE) begin
         div_d = tick_s ? {DVW{1'b0}} : div_q + DVW'(1);
         fb_d  = tick_s ? fb_q + FW'(1) : fb_q;
      end else begin
         div_d = {DVW{1'b0}};
         fb_d  = fb_q;
      end

      case (state_q)
         IDLE: begin
            start_d  = 1'b0;
            data_d   = {DWIDTH{1'b0}};
            launch_s = enable;
         end
         LOAD: begin
            if (tick_s) begin
               start_d = 1'b0;
               if (idx_q < STAGE_I) begin
                  data_d = active_q[idx_q[AW-1:0]];
                  idx_d  = idx_q + IW'(1);
               end else begin
                  data_d  = {DWIDTH{1'b0}};
                  state_d = GAP;
               end
            end else begin
               start_d = start_q;
            end
         end
         GAP: begin
            start_d = 1'b0;
            data_d  = {DWIDTH{1'b0}};
            if (tick_s && (fb_q == FB_LAST)) begin
               frame_done_d = 1'b1;
               frame_cnt_d  = frame_cnt_q + 16'd1;
               if (enable) begin
                  launch_s = 1'b1;
               end else begin
                  state_d = IDLE;
                  fb_d    = {FW{1'b0}};
               end
            end else begin
               frame_done_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            start_d = 1'b0;
            data_d  = {DWIDTH{1'b0}};
         end
      endcase

      // A launch swaps in the committed set and drives its beat-0 value directly.
      if (launch_s) begin
         state_d          = LOAD;
         start_d          = 1'b1;
         data_d           = commit_pending_q ? shadow_q[0] : active_q[0];
         idx_d            = IW'(1);
         fb_d             = {FW{1'b0}};
         div_d            = {DVW{1'b0}};
         commit_pending_d = commit;
      end else begin
         idx_d = idx_d;
      end

      busy_d = (state_d != IDLE);
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         start_q          <= 1'b0;
         data_q           <= {DWIDTH{1'b0}};
         busy_q           <= 1'b0;
         commit_pending_q <= 1'b0;
         frame_done_q     <= 1'b0;
         frame_cnt_q      <= 16'd0;
         div_q            <= {DVW{1'b0}};
         fb_q             <= {FW{1'b0}};
         idx_q            <= {IW{1'b0}};
      end else begin
         state_q          <= state_d;
         start_q          <= start_d;
         data_q           <= data_d;
         busy_q           <= busy_d;
         commit_pending_q <= commit_pending_d;
         frame_done_q     <= frame_done_d;
         frame_cnt_q      <= frame_cnt_d;
         div_q            <= div_d;
         fb_q             <= fb_d;
         idx_q            <= idx_d;
      end
   end

   // Duty buffers: the copy reads pre-edge shadow, so a same-cycle write misses it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGE; i++) begin
            shadow_q[i] <= {DWIDTH{1'b0}};
            active_q[i] <= {DWIDTH{1'b0}};
         end
      end else begin
         if (launch_s && commit_pending_q) begin
            for (int i = 0; i < STAGE; i++) begin
               active_q[i] <= shadow_q[i];
            end
         end
         if (wr_en && wr_ok_s) begin
            shadow_q[wr_addr] <= wr_data;
         end
      end
   end

   assign start          = start_q;
   assign data           = data_q;
   assign busy           = busy_q;
   assign commit_pending = commit_pending_q;
   assign frame_done     = frame_done_q;
   assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_pwm_frame_sequencer.sv
// Bench for pwm_frame_sequencer: directed vector table, hand-written corner
// sequences and random traffic checked against a frame-time reference model.
module tb_pwm_frame_sequencer;

   localparam int S   = 8;
   localparam int BD  = 32;
   localparam int FBT = 24;
   localparam int FL  = BD * FBT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0, wr_en = 1'b0, commit = 1'b0;
   logic [2:0]  wr_addr = 3'd0;
   logic [7:0]  wr_data = 8'd0;
   logic        start, busy, commit_pending, frame_done;
   logic [7:0]  data;
   logic [15:0] frame_cnt;

   logic        en6 = 1'b0, we6 = 1'b0, cm6 = 1'b0;
   logic [2:0]  wa6 = 3'd0;
   logic [7:0]  wd6 = 8'd0;
   logic        st6, bz6, cp6, fd6;
   logic [7:0]  dt6;
   logic [15:0] fc6;

   int total = 0;
   int bad = 0;
   int off = 0;

   // reference model: time since launch within a frame
   logic        m_run, m_pend, m_fd;
   int          m_t;
   logic [15:0] m_fc;
   logic [7:0]  m_sh [S];
   logic [7:0]  m_act [S];

   typedef struct {
      int          off;
      logic        st;
      logic [7:0]  dat;
      logic        fd;
      logic [15:0] fc;
   } vec_t;
   vec_t tbl [12];

   pwm_frame_sequencer #(.STAGE(S), .DWIDTH(8), .BEAT_DIV(BD), .FRAME_BEATS(FBT)) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .commit(commit), .start(start), .data(data), .busy(busy),
      .commit_pending(commit_pending), .frame_done(frame_done), .frame_cnt(frame_cnt));

   pwm_frame_sequencer #(.STAGE(6), .DWIDTH(8), .BEAT_DIV(2), .FRAME_BEATS(8)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .enable(en6), .wr_en(we6), .wr_addr(wa6),
      .wr_data(wd6), .commit(cm6), .start(st6), .data(dt6), .busy(bz6),
      .commit_pending(cp6), .frame_done(fd6), .frame_cnt(fc6));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [27:0] dut_vec();
      return {start, data, busy, commit_pending, frame_done, frame_cnt};
   endfunction

   function automatic logic [27:0] model_vec();
      int         b;
      logic       s;
      logic [7:0] d;
      b = m_t / BD;
      s = m_run && (m_t < BD);
      d = 8'h00;
      if (m_run && b < S) d = m_act[b];
      return {s, d, m_run, m_pend, m_fd, m_fc};
   endfunction

   task automatic model_step();
      logic launch;
      if (!rst_n) begin
         m_run = 1'b0; m_pend = 1'b0; m_fd = 1'b0; m_t = 0; m_fc = 16'd0;
         for (int i = 0; i < S; i++) begin m_sh[i] = 8'd0; m_act[i] = 8'd0; end
         return;
      end
      m_fd = 1'b0;
      launch = 1'b0;
      if (!m_run) begin
         launch = enable;
      end else begin
         m_t++;
         if (m_t == FL) begin
            m_fd = 1'b1;
            m_fc = m_fc + 16'd1;
            if (enable) launch = 1'b1;
            else m_run = 1'b0;
         end
      end
      if (launch) begin
         if (m_pend) m_act = m_sh;
         m_pend = commit;
         m_run = 1'b1;
         m_t = 0;
      end else begin
         m_pend = m_pend | commit;
      end
      if (wr_en && wr_addr < S) m_sh[wr_addr] = wr_data;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("model", dut_vec(), model_vec());
      off++;
   endtask

   task automatic run_to(input int target);
      while (off < target) cyc();
   endtask

   initial begin
      logic       found;
      logic [7:0] e6;

      tbl[0]  = '{0,    1'b1, 8'h10, 1'b0, 16'd0};
      tbl[1]  = '{31,   1'b1, 8'h10, 1'b0, 16'd0};
      tbl[2]  = '{32,   1'b0, 8'h20, 1'b0, 16'd0};
      tbl[3]  = '{100,  1'b0, 8'h40, 1'b0, 16'd0};
      tbl[4]  = '{224,  1'b0, 8'h80, 1'b0, 16'd0};
      tbl[5]  = '{255,  1'b0, 8'h80, 1'b0, 16'd0};
      tbl[6]  = '{256,  1'b0, 8'h00, 1'b0, 16'd0};
      tbl[7]  = '{767,  1'b0, 8'h00, 1'b0, 16'd0};
      tbl[8]  = '{768,  1'b1, 8'h10, 1'b1, 16'd1};
      tbl[9]  = '{769,  1'b1, 8'h10, 1'b0, 16'd1};
      tbl[10] = '{1536, 1'b1, 8'h10, 1'b1, 16'd2};
      tbl[11] = '{2304, 1'b1, 8'h10, 1'b1, 16'd3};

      cyc();
      cyc();
      check("reset_state", dut_vec(), 28'h0);
      check("reset_state6", {st6, dt6, bz6, cp6, fd6, fc6}, 28'h0);
      rst_n = 1'b1;

      // frame timing and back-to-back replay
      for (int i = 0; i < S; i++) begin
         wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(16 * (i + 1));
         cyc();
      end
      wr_en = 1'b0; commit = 1'b1;
      cyc();
      commit = 1'b0; enable = 1'b1;
      cyc();
      off = 0;
      for (int i = 0; i < 12; i++) begin
         run_to(tbl[i].off);
         check("tbl", dut_vec(), {tbl[i].st, tbl[i].dat, 1'b1, 1'b0, tbl[i].fd, tbl[i].fc});
      end

      // mid-frame write and commit wait for the next boundary
      run_to(2400);
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hFF;
      cyc();
      wr_en = 1'b0; commit = 1'b1;
      cyc();
      commit = 1'b0;
      check("old_value_in_flight", {data, commit_pending}, {8'h40, 1'b1});
      run_to(3071);
      check("pending_held", commit_pending, 1'b1);
      run_to(3168);
      check("new_value_applied", {data, commit_pending}, {8'hFF, 1'b0});

      // enable dropped mid-burst
      run_to(3905);
      enable = 1'b0;
      run_to(4069);
      check("burst_completes", {start, data, busy}, {1'b0, 8'h80, 1'b1});
      run_to(4607);
      check("before_boundary", {frame_done, busy}, {1'b0, 1'b1});
      run_to(4608);
      check("stop_boundary", {start, busy, frame_done, frame_cnt}, {1'b0, 1'b0, 1'b1, 16'd6});
      run_to(4700);
      check("stays_idle", {start, data, busy}, {1'b0, 8'h00, 1'b0});

      // STAGE=6 instance: addresses 6 and 7 must be ignored
      for (int a = 0; a < 8; a++) begin
         we6 = 1'b1; wa6 = 3'(a);
         wd6 = (a < 6) ? 8'(a + 1) : 8'(8'hA0 + a);
         cyc();
      end
      we6 = 1'b0; cm6 = 1'b1;
      cyc();
      cm6 = 1'b0; en6 = 1'b1;
      cyc();
      en6 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         e6 = (k < 6) ? 8'(k + 1) : 8'h00;
         check("s6_beat", {st6, dt6, cp6}, {(k == 0), e6, 1'b0});
         cyc();
         cyc();
      end
      check("s6_frame_end", {fd6, bz6, fc6}, {1'b1, 1'b0, 16'd1});

      // random traffic against the model
      for (int n = 0; n < 5000; n++) begin
         enable  = ($urandom_range(0, 99) < 90);
         wr_en   = ($urandom_range(0, 99) < 30);
         wr_addr = 3'($urandom_range(0, 7));
         wr_data = 8'($urandom);
         commit  = ($urandom_range(0, 99) < 5);
         cyc();
      end
      wr_en = 1'b0; commit = 1'b0;

      // asynchronous reset in the middle of beat 4
      enable = 1'b1;
      found = 1'b0;
      for (int n = 0; n < 3000 && !found; n++) begin
         cyc();
         if (m_run && (m_t / BD) == 4) found = 1'b1;
      end
      check("reach_beat4", found, 1'b1);
      rst_n = 1'b0;
      #1;
      check("async_reset", dut_vec(), 28'h0);
      cyc();
      rst_n = 1'b1;
      cyc();
      check("post_reset_burst", {start, data, busy}, {1'b1, 8'h00, 1'b1});
      for (int n = 0; n < 300; n++) cyc();
      enable = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pwm_frame_sequencer.md
Name: pwm_frame_sequencer

Overview:
Single-clock controller that feeds the multi-stage PWM datapath. It holds STAGE duty values in a host-writable shadow buffer and double-buffers them into an active set. It replays the active set as a serial start/data burst, one value per data beat, once per fixed-length frame. Duty updates take effect only on frame boundaries, so a frame never mixes old and new values.

Parameters:
STAGE, 8, number of PWM channels and values per burst
DWIDTH, 8, duty value width
BEAT_DIV, 32, clk cycles per data beat (counter/data clock ratio); must be >= 2
FRAME_BEATS, 24, beats from one start assertion to the next; must be >= STAGE+1

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
enable  in  1  level; run frames while high
wr_en  in  1  write shadow[wr_addr] = wr_data this cycle
wr_addr  in  $clog2(STAGE)  shadow index
wr_data  in  DWIDTH  duty value
commit  in  1  pulse; request shadow->active transfer at next frame boundary
start  out  1  high for exactly the first beat of each burst
data  out  DWIDTH  duty value for current beat; 0 outside the burst
busy  out  1  state != IDLE
commit_pending  out  1  commit requested, not yet applied
frame_done  out  1  one-clk pulse at the end of each frame
frame_cnt  out  16  completed frames, wraps 16'hFFFF -> 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; start, data, busy, commit_pending, frame_done, frame_cnt all 0; shadow and active arrays 0; divider, beat and index counters 0.
- Outputs are registered. start/data change only on a beat edge and hold for BEAT_DIV clks.
- Divider: div counts 0..BEAT_DIV-1 while state != IDLE. tick = (div==BEAT_DIV-1). div is held at 0 in IDLE.
- Beat counter fb counts beats within the frame: 0 = start beat, and it increments on tick.
- IDLE:
  - Outputs 0.
  - When enable=1 is sampled, perform a launch at that edge: apply a pending commit; start<=1; data<=value[0]; idx<=1; fb<=0; div<=0; state<=LOAD.
  - Launch latency: start is visible 1 clk after enable is first sampled high.
- LOAD, on tick:
  - If idx<STAGE: start<=0, data<=active[idx], idx++.
  - Else: data<=0, state<=GAP.
  - Value i is presented during beat i, i=0..STAGE-1.
- GAP:
  - Outputs 0.
  - On tick with fb==FRAME_BEATS-1: frame_done<=1 for one clk and frame_cnt++.
  - Then, if enable=1: launch (same actions as from IDLE), giving back-to-back frames with period exactly FRAME_BEATS*BEAT_DIV clks.
  - Otherwise state<=IDLE.
- enable deasserted mid-frame: the frame always completes, including frame_done. The block returns to IDLE at the boundary. No truncated bursts.
- Shadow writes:
  - Accepted in any state.
  - wr_addr >= STAGE is ignored: no write, no error.
- Commit:
  - commit sets commit_pending.
  - At a launch with commit_pending=1: active<=shadow (pre-edge shadow contents), commit_pending<=0, and data<=shadow[0] is driven directly so the new set starts on beat 0.
  - Without a pending commit, value[0] = active[0].
- Simultaneous events:
  - commit in the launch cycle is not applied to that frame. commit_pending stays or becomes 1 and is applied at the next launch.
  - wr_en in the launch cycle updates shadow after the copy, so the write is not in the new active set.
  - Repeated commits while pending collapse into one.
- active never changes except at a launch, so mid-frame writes or commits never alter the burst in flight.

Test Plan:
1. Shadow = {8'h10,20,30,40,50,60,70,80}, commit, then enable=1 -> start high for 32 clks with data=8'h10; then 20..80 each held 32 clks; then data=0 for 16 beats. frame_done pulses at clk 768 after start rises; frame_cnt=1.
2. enable held high for 3 frames -> start rises every 768 clks exactly; frame_cnt=3; no gap clocks between frames.
3. During frame 1 beat 3: write shadow[3]=8'hFF, then commit -> frame 1 still outputs the old value at beat 3; commit_pending=1 until the next launch; frame 2 beat 3 outputs 8'hFF; commit_pending then reads 0.
4. enable dropped at beat 2 -> burst completes through beat 7; frame_done fires; busy falls at the boundary; start stays 0 afterwards.
5. wr_addr=8 (STAGE=8, 3-bit address with index out of range not reachable) and wr_addr=7 write -> with STAGE=6 parameterisation, addresses 6/7 are ignored and the active set is unchanged after commit.
6. rst_n pulsed low at beat 4 -> start, data, busy, commit_pending and frame_cnt read 0 immediately (async); after release with enable=1, a fresh burst starts with data=0 (arrays cleared).
